// File: rtl/md_pad_scanner_pkg.sv
// Shared encodings for the DB9 pad scanner and the protocol mapper:
// pad type codes and bit positions of the joystick and extra-button words.
package md_pad_scanner_pkg;

  typedef enum logic [1:0] {
    PAD_NONE = 2'd0,
    PAD_MD3  = 2'd1,
    PAD_MD6  = 2'd2
  } pad_t;

  // {F2,F1,U,D,L,R}; F1 = pin6, F2 = pin9
  localparam int J_R  = 0;
  localparam int J_L  = 1;
  localparam int J_D  = 2;
  localparam int J_U  = 3;
  localparam int J_F1 = 4;
  localparam int J_F2 = 5;

  // {Mode,X,Y,Z,Start,A}
  localparam int E_A     = 0;
  localparam int E_START = 1;
  localparam int E_Z     = 2;
  localparam int E_Y     = 3;
  localparam int E_X     = 4;
  localparam int E_MODE  = 5;

  localparam logic [5:0] JOY_IDLE = 6'h3F;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for raw pad pins; resets to all ones
// so an unplugged or idle port reads as released.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/md_pad_scanner.sv
// Mega Drive 3/6-button / Atari pad scanner: drives select through
// eight phases per frame and commits a coherent button word.
module md_pad_scanner #(
  parameter int SCAN_DIV  = 280,
  parameter int FRAME_DIV = 560000,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] db9_in,
  output logic       db9_sel,
  output logic [5:0] joy_out,
  output logic [5:0] joy_ext,
  output logic [1:0] pad_type,
  output logic       scan_done
);

  import md_pad_scanner_pkg::*;

  localparam logic [CNT_W-1:0] B1 = CNT_W'(1 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B2 = CNT_W'(2 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B3 = CNT_W'(3 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B4 = CNT_W'(4 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B5 = CNT_W'(5 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B6 = CNT_W'(6 * SCAN_DIV);
  localparam logic [CNT_W-1:0] B7 = CNT_W'(7 * SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_P1 = CNT_W'(2 * SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_P2 = CNT_W'(3 * SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_P4 = CNT_W'(5 * SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_P5 = CNT_W'(6 * SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_CM = CNT_W'(8 * SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  // Select is low in even phases, high in odd phases and idle.
  function automatic logic sel_of(input logic [CNT_W-1:0] c);
    sel_of = !((c < B1) ||
               (c >= B2 && c < B3) ||
               (c >= B4 && c < B5) ||
               (c >= B6 && c < B7));
  endfunction

  logic [5:0] sync_w;

  sync_2ff #(.W(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (db9_in),
    .q     (sync_w)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [5:0]       s1_q, s1_d;
  logic [3:0]       s2_q, s2_d;
  logic [3:0]       s4_q, s4_d;
  logic [3:0]       s5_q, s5_d;
  logic [5:0]       joy_q, joy_d;
  logic [5:0]       ext_q, ext_d;
  pad_t             type_q, type_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             md_w;
  logic             six_w;

  // s2 holds {pin9,pin6,L,R}; s4/s5 hold {U,D,L,R}
  assign md_w  = (s2_q[1:0] == 2'b00);
  assign six_w = md_w && (s4_q == 4'h0);

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s4_d   = s4_q;
    s5_d   = s5_q;
    joy_d  = joy_q;
    ext_d  = ext_q;
    type_d = type_q;
    done_d = 1'b0;
    pass_d = !enable;
    if (!enable) begin
      cnt_d  = '0;
      sel_d  = 1'b1;
      joy_d  = sync_w;
      ext_d  = JOY_IDLE;
      type_d = PAD_NONE;
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      sel_d = sel_of(cnt_d);
      unique case (1'b1)
        (cnt_q == CNT_P1): s1_d = sync_w;
        (cnt_q == CNT_P2): s2_d = {sync_w[J_F2], sync_w[J_F1],
                                   sync_w[J_L], sync_w[J_R]};
        (cnt_q == CNT_P4): s4_d = sync_w[3:0];
        (cnt_q == CNT_P5): s5_d = sync_w[3:0];
        (cnt_q == CNT_CM): begin
          done_d = 1'b1;
          joy_d  = s1_q;
          ext_d  = JOY_IDLE;
          type_d = PAD_NONE;
          if (md_w) begin
            ext_d[E_A]     = s2_q[2];
            ext_d[E_START] = s2_q[3];
            type_d         = PAD_MD3;
          end
          if (six_w) begin
            ext_d[E_Z]    = s5_q[J_U];
            ext_d[E_Y]    = s5_q[J_D];
            ext_d[E_X]    = s5_q[J_L];
            ext_d[E_MODE] = s5_q[J_R];
            type_d        = PAD_MD6;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 1'b1;
      s1_q   <= '1;
      s2_q   <= '1;
      s4_q   <= '1;
      s5_q   <= '1;
      joy_q  <= JOY_IDLE;
      ext_q  <= JOY_IDLE;
      type_q <= PAD_NONE;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s4_q   <= s4_d;
      s5_q   <= s5_d;
      joy_q  <= joy_d;
      ext_q  <= ext_d;
      type_q <= type_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  // Passthrough shows the synchronizer directly for 2-cycle latency.
  assign db9_sel   = sel_q;
  assign joy_out   = pass_q ? sync_w : joy_q;
  assign joy_ext   = ext_q;
  assign pad_type  = type_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_md_pad_scanner.sv
// Bench for md_pad_scanner: pad BFM with 6-button select counter,
// frame-level model of committed outputs, directed scenarios.
module tb_md_pad_scanner;

  localparam int SD = 4;
  localparam int FD = 64;
  localparam int K_NONE  = 0;
  localparam int K_ATARI = 1;
  localparam int K_MD3   = 2;
  localparam int K_MD6   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [5:0] db9_in;
  logic       db9_sel;
  logic [5:0] joy_out;
  logic [5:0] joy_ext;
  logic [1:0] pad_type;
  logic       scan_done;

  int total = 0;
  int bad = 0;

  int         kind = K_ATARI;
  logic [5:0] atari = 6'h3F;
  logic [5:0] btn_joy = 6'h3F;
  logic [5:0] btn_ext = 6'h3F;
  int         lows = 0;
  int         hi = 0;
  logic       sel_prev = 1'b1;

  md_pad_scanner #(
    .SCAN_DIV  (SD),
    .FRAME_DIV (FD),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .db9_in    (db9_in),
    .db9_sel   (db9_sel),
    .joy_out   (joy_out),
    .joy_ext   (joy_ext),
    .pad_type  (pad_type),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    db9_in = 6'h3F;
    case (kind)
      K_ATARI: db9_in = atari;
      K_MD3: begin
        if (db9_sel) db9_in = btn_joy;
        else db9_in = {btn_ext[1], btn_ext[0], btn_joy[3], btn_joy[2], 2'b00};
      end
      K_MD6: begin
        if (db9_sel) begin
          if (lows == 3)
            db9_in = {btn_joy[5:4], btn_ext[2], btn_ext[3], btn_ext[4], btn_ext[5]};
          else
            db9_in = btn_joy;
        end else if (lows == 3) db9_in = {btn_ext[1:0], 4'b0000};
        else if (lows >= 4) db9_in = {btn_ext[1:0], 4'b1111};
        else db9_in = {btn_ext[1:0], btn_joy[3:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Pad-side select counter with a timeout on long select-high.
  always @(negedge clk) begin
    if (!db9_sel && sel_prev && lows < 8) lows = lows + 1;
    if (db9_sel) begin
      hi = hi + 1;
      if (hi >= 16) lows = 0;
    end else hi = 0;
    sel_prev = db9_sel;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int         pos;
  logic [5:0] hist0, hist1;
  logic [5:0] m_joy, m_ext, snap_joy;
  logic [1:0] snap_sa;
  logic [3:0] snap_hi;
  int         m_type;
  logic       m_sel, m_done, m_pass, m_prev_en, joy_known;
  logic       snap_md, snap_six;
  logic       cap_en;
  logic [5:0] cap_din;
  int         pre;

  always @(posedge clk) begin
    cap_en = enable;
    cap_din = db9_in;
    if (!rst_n) begin
      pos = 0; hist0 = 6'h3F; hist1 = 6'h3F;
      m_joy = 6'h3F; m_ext = 6'h3F; m_type = 0;
      m_sel = 1'b1; m_done = 1'b0; m_pass = 1'b0;
      m_prev_en = 1'b1; joy_known = 1'b1;
      snap_joy = 6'h3F; snap_sa = 2'b11; snap_hi = 4'hF;
      snap_md = 1'b0; snap_six = 1'b0;
    end else begin
      hist1 = hist0;
      hist0 = cap_din;
      m_done = 1'b0;
      pre = pos;
      if (!cap_en) begin
        pos = 0; m_pass = 1'b1; m_sel = 1'b1;
        m_ext = 6'h3F; m_type = 0; m_prev_en = 1'b0;
      end else begin
        if (!m_prev_en) joy_known = 1'b0;
        m_prev_en = 1'b1;
        m_pass = 1'b0;
        if (pre == 2*SD-1)
          snap_joy = (kind == K_ATARI) ? atari :
                     (kind == K_NONE) ? 6'h3F : btn_joy;
        if (pre == 3*SD-1) begin
          snap_sa = btn_ext[1:0];
          snap_md = (kind == K_MD3 || kind == K_MD6);
        end
        if (pre == 5*SD-1) snap_six = (kind == K_MD6);
        if (pre == 6*SD-1) snap_hi = btn_ext[5:2];
        if (pre == 8*SD) begin
          m_joy = snap_joy;
          joy_known = 1'b1;
          m_done = 1'b1;
          if (!snap_md) begin
            m_ext = 6'h3F; m_type = 0;
          end else if (snap_six) begin
            m_ext = {snap_hi, snap_sa}; m_type = 2;
          end else begin
            m_ext = {4'hF, snap_sa}; m_type = 1;
          end
        end
        pos = (pos == FD-1) ? 0 : pos + 1;
        m_sel = (pos < 8*SD && ((pos / SD) % 2 == 0)) ? 1'b0 : 1'b1;
      end
      #1;
      if (rst_n) begin
        chk("sel", int'(db9_sel), int'(m_sel));
        chk("done", int'(scan_done), int'(m_done));
        chk("ext", int'(joy_ext), int'(m_ext));
        chk("type", int'(pad_type), m_type);
        if (m_pass) chk("pass_joy", int'(joy_out), int'(hist1));
        else if (joy_known) chk("joy", int'(joy_out), int'(m_joy));
      end
    end
  end

  task automatic wait_done(input int lim, output int n);
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      if (scan_done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: no scan_done within %0d cycles", lim);
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    @(negedge clk);
    while (pos != p && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (pos != p) begin
      total++; bad++;
      $display("FAIL pos_timeout: pos %0d never reached", p);
    end
  endtask

  initial begin
    int n, edges, idle, per, cnt;
    logic prev;
    #2 rst_n = 1'b0;
    atari = 6'b111011;
    #1;
    chk("rst_sel", int'(db9_sel), 1);
    chk("rst_joy", int'(joy_out), 'h3F);
    chk("rst_ext", int'(joy_ext), 'h3F);
    chk("rst_type", int'(pad_type), 0);
    chk("rst_done", int'(scan_done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    wait_done(200, n);
    chk("atari_lat", n, 33);
    chk("atari_joy", int'(joy_out), 'h3B);
    chk("atari_type", int'(pad_type), 0);
    chk("atari_ext", int'(joy_ext), 'h3F);

    wait_pos(12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", int'(db9_sel), 1);
    chk("mid_rst_joy", int'(joy_out), 'h3F);
    chk("mid_rst_ext", int'(joy_ext), 'h3F);
    chk("mid_rst_type", int'(pad_type), 0);
    enable = 1'b0;
    kind = K_MD3;
    btn_joy = 6'h2F;
    btn_ext = 6'h3D;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    wait_done(200, n);
    chk("md3_lat", n, 33);
    chk("md3_joy", int'(joy_out), 'h2F);
    chk("md3_ext", int'(joy_ext), 'h3D);
    chk("md3_type", int'(pad_type), 1);

    @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    kind = K_MD6;
    btn_joy = 6'h3F;
    btn_ext = 6'h0E;
    enable = 1'b1;
    wait_done(200, n);
    chk("md6_joy", int'(joy_out), 'h3F);
    chk("md6_ext", int'(joy_ext), 'h0E);
    chk("md6_type", int'(pad_type), 2);
    prev = db9_sel; edges = 0; idle = 0; per = 0;
    for (int i = 1; i <= FD; i++) begin
      @(posedge clk); #1;
      if (db9_sel != prev) edges++;
      prev = db9_sel;
      if (pos >= 8*SD && db9_sel) idle++;
      if (scan_done && per == 0) per = i;
    end
    chk("sel_edges", edges, 8);
    chk("idle_high", idle, 32);
    chk("done_period", per, 64);

    wait_pos(14);
    btn_joy = 6'h3E;
    btn_ext = 6'h3E;
    wait_done(200, n);
    chk("mid_joy_old", int'(joy_out), 'h3F);
    chk("mid_ext", int'(joy_ext), 'h3E);
    wait_done(200, n);
    chk("next_period", n, 64);
    chk("mid_joy_new", int'(joy_out), 'h3E);
    chk("mid_type", int'(pad_type), 2);

    wait_pos(10);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (scan_done) cnt++;
    end
    chk("abort_done", cnt, 0);
    chk("abort_sel", int'(db9_sel), 1);
    @(negedge clk);
    kind = K_ATARI;
    atari = 6'h15;
    repeat (3) @(posedge clk);
    #1;
    chk("pass_a", int'(joy_out), 'h15);
    @(negedge clk);
    atari = 6'h2A;
    @(posedge clk); #1;
    chk("pass_lat1", int'(joy_out), 'h15);
    @(posedge clk); #1;
    chk("pass_lat2", int'(joy_out), 'h2A);
    @(negedge clk);
    enable = 1'b1;
    wait_done(200, n);
    chk("reen_lat", n, 33);
    chk("reen_joy", int'(joy_out), 'h2A);
    chk("reen_type", int'(pad_type), 0);
    chk("reen_ext", int'(joy_ext), 'h3F);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
